// File: rtl/rv_pkg.sv
// Shared RV32 register-file constants and the writeback queue entry layout.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REGW = 5;

    // One queued long-latency result: destination register plus data.
    localparam int WB_W = REGW + XLEN;

    typedef struct packed {
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    function automatic wb_entry_t make_entry(input logic [REGW-1:0] rd,
                                             input logic [XLEN-1:0] data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/gpr_writeback_wb_fifo.sv
// Circular FIFO holding long-latency results awaiting a free writeback slot.
// Wrapping pointers of log2(DEPTH) bits plus an occupancy counter one bit wider.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WB_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // Full/empty are sampled before this cycle's pop, so a full queue never
    // accepts a push even if it drains in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/gpr_writeback.sv
// Register-file writeback arbiter: ALU results win, long-latency results are
// bypassed or queued. Optional hazard checker enabled by GPR_WB_CHECK_EN.
module gpr_writeback
    import rv_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_we,
    input  logic [REGW-1:0] alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [REGW-1:0] ll_rd,
    input  logic [XLEN-1:0] ll_data,
    input  logic            iss_valid,
    input  logic [REGW-1:0] iss_rd,
    output logic            we,
    output logic [REGW-1:0] rd,
    output logic [XLEN-1:0] rrd,
    output logic [NREG-1:0] busy
);

    localparam int CW = $clog2(QDEPTH) + 1;

    // Handshake: a long-latency beat transfers in any cycle where ll_valid and
    // ll_ready are both 1; ll_ready depends only on queue occupancy.
    logic            q_full;
    logic            q_empty_flag;
    logic [CW-1:0]   q_count;
    logic            q_empty;
    logic            q_push;
    logic            q_pop;
    wb_entry_t       q_head;
    wb_entry_t       q_in;

    logic            ll_accept;
    logic            alu_sel;
    logic            sel_valid;
    logic            sel_is_ll;
    logic [REGW-1:0] sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            we_q;
    logic [REGW-1:0] rd_q;
    logic [XLEN-1:0] rrd_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;

    assign ll_ready  = !q_full;
    assign ll_accept = ll_valid && ll_ready;
    assign alu_sel   = alu_we && (alu_rd != '0);
    assign q_empty   = (q_count == '0);
    assign q_in      = make_entry(ll_rd, ll_data);

    wb_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (WB_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty_flag),
        .count     (q_count)
    );

    // Selection: ALU first, then the queue head, then a same-cycle bypass.
    // Beats targeting x0 still handshake but never enter the queue.
    always_comb begin
        sel_valid = 1'b0;
        sel_is_ll = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        q_pop     = 1'b0;
        q_push    = 1'b0;
        if (alu_sel) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (!q_empty_flag) begin
            q_pop     = 1'b1;
            sel_valid = 1'b1;
            sel_is_ll = 1'b1;
            sel_rd    = q_head.rd;
            sel_data  = q_head.data;
        end else if (ll_accept && (ll_rd != '0)) begin
            sel_valid = 1'b1;
            sel_is_ll = 1'b1;
            sel_rd    = ll_rd;
            sel_data  = ll_data;
        end
        if (ll_accept && (ll_rd != '0) && !(q_empty && !alu_sel)) begin
            q_push = 1'b1;
        end
    end

    // A same-cycle set on the register being cleared wins: a new issue to it
    // is still outstanding.
    always_comb begin
        busy_next = busy_q;
        if (sel_valid && sel_is_ll) begin
            busy_next[sel_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            rrd_q  <= '0;
            busy_q <= '0;
        end else begin
            we_q   <= sel_valid;
            rd_q   <= sel_valid ? sel_rd : '0;
            rrd_q  <= sel_valid ? sel_data : '0;
            busy_q <= busy_next;
        end
    end

    assign we   = we_q;
    assign rd   = rd_q;
    assign rrd  = rrd_q;
    assign busy = busy_q;

`ifdef GPR_WB_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if (alu_sel && busy_q[alu_rd]) begin
                $fatal(1, "gpr_writeback: WAW hazard, ALU write to busy x%0d", alu_rd);
            end
            if (ll_accept && (ll_rd != '0) && !busy_q[ll_rd]) begin
                $fatal(1, "gpr_writeback: long-latency write to non-busy x%0d", ll_rd);
            end
        end
    end
`else
    // Hazard checking compiled out.
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed table-driven bench for gpr_writeback plus an ordered drain sequence.
module tb_gpr_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rrd;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpr_writeback #(.QDEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_we    (alu_we),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ll_valid  (ll_valid),
        .ll_ready  (ll_ready),
        .ll_rd     (ll_rd),
        .ll_data   (ll_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .rd        (rd),
        .rrd       (rrd),
        .busy      (busy)
    );

    typedef struct {
        logic        rst;
        logic        alu_we;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        ll_valid;
        logic [4:0]  ll_rd;
        logic [31:0] ll_data;
        logic        iss_valid;
        logic [4:0]  iss_rd;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_rrd;
        logic        e_ready;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];
    logic [36:0] exp_q[$];

    function automatic vec_t mk(input logic r, input logic aw, input logic [4:0] ar,
                                input logic [31:0] ad, input logic lv, input logic [4:0] lr,
                                input logic [31:0] ld, input logic iv, input logic [4:0] ir,
                                input logic ew, input logic [4:0] er, input logic [31:0] ed,
                                input logic ey, input logic [31:0] eb);
        vec_t v;
        v.rst = r; v.alu_we = aw; v.alu_rd = ar; v.alu_data = ad;
        v.ll_valid = lv; v.ll_rd = lr; v.ll_data = ld;
        v.iss_valid = iv; v.iss_rd = ir;
        v.e_we = ew; v.e_rd = er; v.e_rrd = ed; v.e_ready = ey; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic aw, input logic [4:0] ar,
                         input logic [31:0] ad, input logic lv, input logic [4:0] lr,
                         input logic [31:0] ld, input logic iv, input logic [4:0] ir);
        rst = r; alu_we = aw; alu_rd = ar; alu_data = ad;
        ll_valid = lv; ll_rd = lr; ll_data = ld; iss_valid = iv; iss_rd = ir;
    endtask

    initial begin
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, then single ALU write.
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0,  1, 5, 32'hDEADBEEF, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        // Bypass of x7.
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 7,  0, 0, 0,            1, 32'h80));
        vecs.push_back(mk(1, 0, 0, 0,            1, 7, 32'h11, 0, 0,  1, 7, 32'h11,       1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        // ALU x3 and LL x9 collide.
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 9,  0, 0, 0,            1, 32'h200));
        vecs.push_back(mk(1, 1, 3, 32'h33,       1, 9, 32'h99, 0, 0,  1, 3, 32'h33,       1, 32'h200));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  1, 9, 32'h99,       1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        // x0 targets are dropped.
        vecs.push_back(mk(1, 1, 0, 32'h55,       1, 0, 32'h66, 0, 0,  0, 0, 0,            1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 0,  0, 0, 0,            1, 32'h0));
        // Set and clear of x12 in one cycle keeps it busy.
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 12, 0, 0, 0,            1, 32'h1000));
        vecs.push_back(mk(1, 0, 0, 0,            1, 12, 32'hC, 1, 12, 1, 12, 32'hC,       1, 32'h1000));
        vecs.push_back(mk(1, 0, 0, 0,            1, 12, 32'hD, 0, 0,  1, 12, 32'hD,       1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        // Fill the queue behind six ALU writes, then drain in order.
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 20, 0, 0, 0,            1, 32'h00100000));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 21, 0, 0, 0,            1, 32'h00300000));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 22, 0, 0, 0,            1, 32'h00700000));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 23, 0, 0, 0,            1, 32'h00F00000));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 24, 0, 0, 0,            1, 32'h01F00000));
        vecs.push_back(mk(1, 1, 1, 32'hA1,       1, 20, 32'h200, 0, 0, 1, 1, 32'hA1,      1, 32'h01F00000));
        vecs.push_back(mk(1, 1, 2, 32'hA2,       1, 21, 32'h210, 0, 0, 1, 2, 32'hA2,      1, 32'h01F00000));
        vecs.push_back(mk(1, 1, 3, 32'hA3,       1, 22, 32'h220, 0, 0, 1, 3, 32'hA3,      1, 32'h01F00000));
        vecs.push_back(mk(1, 1, 4, 32'hA4,       1, 23, 32'h230, 0, 0, 1, 4, 32'hA4,      0, 32'h01F00000));
        vecs.push_back(mk(1, 1, 5, 32'hA5,       1, 24, 32'h240, 0, 0, 1, 5, 32'hA5,      0, 32'h01F00000));
        vecs.push_back(mk(1, 1, 6, 32'hA6,       1, 24, 32'h240, 0, 0, 1, 6, 32'hA6,      0, 32'h01F00000));
        vecs.push_back(mk(1, 0, 0, 0,            1, 24, 32'h240, 0, 0, 1, 20, 32'h200,    1, 32'h01E00000));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  1, 21, 32'h210,     1, 32'h01C00000));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  1, 22, 32'h220,     1, 32'h01800000));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  1, 23, 32'h230,     1, 32'h01000000));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h01000000));
        // Reset with three entries queued loses them all.
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      1, 25, 0, 0, 0,            1, 32'h03000000));
        vecs.push_back(mk(1, 1, 8, 32'h81,       1, 24, 32'h240, 0, 0, 1, 8, 32'h81,      1, 32'h03000000));
        vecs.push_back(mk(1, 1, 8, 32'h82,       1, 25, 32'h250, 0, 0, 1, 8, 32'h82,      1, 32'h03000000));
        vecs.push_back(mk(1, 1, 8, 32'h83,       1, 24, 32'h241, 0, 0, 1, 8, 32'h83,      1, 32'h03000000));
        vecs.push_back(mk(0, 1, 8, 32'h84,       0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));
        vecs.push_back(mk(1, 1, 31, 32'hFFFFFFFF, 0, 0, 0,     0, 0,  1, 31, 32'hFFFFFFFF, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      0, 0,  0, 0, 0,            1, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].alu_we, vecs[i].alu_rd, vecs[i].alu_data,
                  vecs[i].ll_valid, vecs[i].ll_rd, vecs[i].ll_data,
                  vecs[i].iss_valid, vecs[i].iss_rd);
            @(posedge clk);
            #1;
            chk("we",       i, {31'h0, we},       {31'h0, vecs[i].e_we});
            chk("rd",       i, {27'h0, rd},       {27'h0, vecs[i].e_rd});
            chk("rrd",      i, rrd,               vecs[i].e_rrd);
            chk("ll_ready", i, {31'h0, ll_ready}, {31'h0, vecs[i].e_ready});
            chk("busy",     i, busy,              vecs[i].e_busy);
        end

        // Enqueue while draining a non-full queue: writes must come out in
        // arrival order, ALU results first.
        exp_q.push_back({5'd2,  32'h2});
        exp_q.push_back({5'd3,  32'h3});
        exp_q.push_back({5'd14, 32'hE0});
        exp_q.push_back({5'd15, 32'hF0});
        exp_q.push_back({5'd16, 32'h100});
        for (int c = 0; c < 12; c++) begin
            case (c)
                0:       drive(1, 1, 2, 32'h2, 1, 14, 32'hE0,  0, 0);
                1:       drive(1, 1, 3, 32'h3, 1, 15, 32'hF0,  0, 0);
                2:       drive(1, 0, 0, 0,     1, 16, 32'h100, 0, 0);
                default: drive(1, 0, 0, 0,     0, 0,  0,       0, 0);
            endcase
            @(posedge clk);
            #1;
            if (we) begin
                if (exp_q.size() == 0) begin
                    chk("drain_extra", 100 + c, {27'h0, rd}, 32'h0);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    chk("drain_rd",  100 + c, {27'h0, rd}, {27'h0, e[36:32]});
                    chk("drain_rrd", 100 + c, rrd,         e[31:0]);
                end
            end
        end
        chk("drain_left", 200, exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
